// File: rtl/mips_multicycle_control_pkg.sv
// mips_ctrl_pkg: shared types for the multi-cycle MIPS main control.
//   state_e   : controller states (4-bit encoding)
//   OP_*      : supported instruction opcodes (IR[31:26])
//   alu_op_e, alu_src_b_e, pc_source_e : datapath select encodings
//   ctrl_t    : bundle of every datapath select/enable
//   ctrl_decode() : Moore decode of a state into ctrl_t
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11,
        HALT    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_S2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PCS_ALU    = 2'b00,
        PCS_ALUOUT = 2'b01,
        PCS_JUMP   = 2'b10
    } pc_source_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        pc_source_e pc_source;
    } ctrl_t;

    // States that sit on the memory handshake and are guarded by the wait timer.
    function automatic logic is_wait_state(state_e s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

    // Pure Moore decode, except FETCH only commits PC/IR once memory delivers.
    function automatic ctrl_t ctrl_decode(state_e s, logic mem_ready);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
            end
            DECODE:  c.alu_src_b = SRCB_IMM_S2;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCS_ALUOUT;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_JUMP;
            end
            ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            ADDIWB:  c.reg_write = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: control <-> datapath signal bundle.
//   master : the control FSM (drives selects/enables, status flags)
//   slave  : the datapath/memory side (drives opcode, zero, mem_ready)
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
    logic       illegal_op;
    logic       bus_error;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, halted, illegal_op, bus_error
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, halted, illegal_op, bus_error
    );
endinterface

// File: rtl/mips_multicycle_control_timer.sv
// mc_wait_timer: memory-wait watchdog.
//   clk, rst : clock, async active-high reset
//   clr_i    : clear the count (new wait state or handshake completed)
//   inc_i    : one more cycle spent waiting
//   last_o   : current waiting cycle is the WAIT_LIMIT-th one
// WAIT_LIMIT must be in 1 .. 2**WAIT_W-1.
module mc_wait_timer #(
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);
    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(WAIT_LIMIT - 1);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    // The count holds cycles already waited, so the cycle that would make it
    // reach WAIT_LIMIT is the one where it still equals WAIT_LIMIT-1.
    assign last_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !last_o)
            cnt_d = cnt_q + WAIT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: main control FSM of the multi-cycle MIPS datapath.
//   clk, reset : clock, async active-high reset (all outputs 0 while high)
//   bus        : master side of mips_multicycle_control_if
//                in : opcode, zero, mem_ready
//                out: datapath selects/enables, halted, illegal_op, bus_error
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    mips_multicycle_control_if.master  bus
);
    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   bus_error_q, bus_error_d;
    logic   wt_clr, wt_last;
    ctrl_t  ctrl;

    // zero is qualified against pc_write_cond in the datapath's PC enable.
    logic unused_zero;
    assign unused_zero = bus.zero;

    // Count only while a handshake state is stalled; any other state or a
    // completed handshake clears, which also gives a clean count on entry.
    assign wt_clr = bus.mem_ready || !is_wait_state(state_q);

    mc_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT),
        .WAIT_W    (WAIT_W)
    ) u_wait (
        .clk   (clk),
        .rst   (reset),
        .clr_i (wt_clr),
        .inc_i (!wt_clr),
        .last_o(wt_last)
    );

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        case (state_q)
            FETCH: begin
                if (bus.mem_ready) state_d = DECODE;
                else if (wt_last) begin
                    state_d     = HALT;
                    bus_error_d = 1'b1;
                end
            end
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEX;
                    default: begin
                        state_d   = HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            // IR still holds the instruction, so opcode is stable here.
            MEMADR:  state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD: begin
                if (bus.mem_ready) state_d = MEMWB;
                else if (wt_last) begin
                    state_d     = HALT;
                    bus_error_d = 1'b1;
                end
            end
            MEMWR: begin
                if (bus.mem_ready) state_d = FETCH;
                else if (wt_last) begin
                    state_d     = HALT;
                    bus_error_d = 1'b1;
                end
            end
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Gating by reset itself makes an in-flight write vanish the moment reset
    // rises, rather than at the next clock edge.
    always_comb begin
        ctrl = ctrl_decode(state_q, bus.mem_ready);
        if (reset) ctrl = '0;
    end

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.iord          = ctrl.iord;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.halted        = !reset && (state_q == HALT);
    assign bus.illegal_op    = illegal_q;
    assign bus.bus_error     = bus_error_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: the stimulus walks each instruction through its phases,
// pushing the expected control word for every cycle; a negedge monitor pops
// and compares against what the controller presents.
module tb_mips_multicycle_control;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_multicycle_control_if bus();

    mips_multicycle_control #(.WAIT_LIMIT(4), .WAIT_W(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aop, pcs;
        logic       hlt, ill, berr;
    } ctl_t;

    typedef enum int {
        PH_RST, PH_F, PH_D, PH_MA, PH_MR, PH_MWB, PH_MW,
        PH_EX, PH_AWB, PH_BR, PH_J, PH_AX, PH_IWB, PH_H
    } phase_e;

    ctl_t   exp_q[$];
    phase_e ph_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     sticky_ill = 0, sticky_berr = 0, tie_ready = 0;
    bit     done = 0, drain_checked = 0;
    ctl_t   mon_e, mon_a;
    phase_e mon_p;

    // Control word each instruction phase must present, straight from the
    // per-phase description of the controller.
    function automatic ctl_t expect_for(phase_e ph, logic rdy);
        ctl_t c;
        c = '0;
        case (ph)
            PH_F:   begin c.mrd = 1; c.srcb = 2'b01; c.pcw = rdy; c.irw = rdy; end
            PH_D:   c.srcb = 2'b11;
            PH_MA:  begin c.srca = 1; c.srcb = 2'b10; end
            PH_MR:  begin c.mrd = 1; c.iord = 1; end
            PH_MWB: begin c.rw = 1; c.m2r = 1; end
            PH_MW:  begin c.mwr = 1; c.iord = 1; end
            PH_EX:  begin c.srca = 1; c.aop = 2'b10; end
            PH_AWB: begin c.rw = 1; c.rdst = 1; end
            PH_BR:  begin c.srca = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01; end
            PH_J:   begin c.pcw = 1; c.pcs = 2'b10; end
            PH_AX:  begin c.srca = 1; c.srcb = 2'b10; end
            PH_IWB: c.rw = 1;
            PH_H:   c.hlt = 1;
            default: c = '0;
        endcase
        if (ph != PH_RST) begin
            c.ill  = sticky_ill;
            c.berr = sticky_berr;
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_p = ph_q.pop_front();
            mon_a = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
                     bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                     bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                     bus.pc_source, bus.halted, bus.illegal_op, bus.bus_error};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL ctl#%0d phase %s got %b exp %b",
                         checks, mon_p.name(), mon_a, mon_e);
            end
        end else if (done && !drain_checked) begin
            drain_checked = 1;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain left %0d exp 0", exp_q.size());
            end
        end
    end

    // Called at posedge+1: drive inputs, queue this cycle's expectation.
    task automatic step(phase_e ph, logic [5:0] op, logic z, logic rdy);
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = rdy;
        exp_q.push_back(expect_for(ph, rdy));
        ph_q.push_back(ph);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_rdy();
        return tie_ready ? 1'b1 : 1'($urandom);
    endfunction

    task automatic mem_wait(phase_e ph, logic [5:0] op, logic z, int w);
        for (int i = 0; i < w; i++) step(ph, op, z, 1'b0);
        step(ph, op, z, 1'b1);
    endtask

    // Opcode during FETCH is random: the IR has not captured it yet.
    task automatic run_instr(logic [5:0] op, logic z, int wf, int wm);
        mem_wait(PH_F, 6'($urandom), z, wf);
        step(PH_D, op, z, rnd_rdy());
        case (op)
            LW:   begin step(PH_MA, op, z, rnd_rdy()); mem_wait(PH_MR, op, z, wm);
                        step(PH_MWB, op, z, rnd_rdy()); end
            SW:   begin step(PH_MA, op, z, rnd_rdy()); mem_wait(PH_MW, op, z, wm); end
            RT:   begin step(PH_EX, op, z, rnd_rdy()); step(PH_AWB, op, z, rnd_rdy()); end
            ADDI: begin step(PH_AX, op, z, rnd_rdy()); step(PH_IWB, op, z, rnd_rdy()); end
            BEQ:  step(PH_BR, op, z, rnd_rdy());
            JMP:  step(PH_J, op, z, rnd_rdy());
            default: sticky_ill = 1;
        endcase
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        sticky_ill  = 0;
        sticky_berr = 0;
        step(PH_RST, 6'($urandom), 1'b0, 1'b1);
        step(PH_RST, 6'($urandom), 1'b1, 1'b1);
        reset = 1'b0;
    endtask

    task automatic halt_cycles(int n);
        for (int i = 0; i < n; i++) step(PH_H, 6'($urandom), 1'($urandom), 1'($urandom));
    endtask

    logic [5:0] legal [6] = '{LW, SW, RT, ADDI, BEQ, JMP};

    initial begin
        reset = 1'b1;
        bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Zero-wait sequence with mem_ready tied high.
        tie_ready = 1;
        foreach (legal[i]) run_instr(legal[i], 1'b0, 0, 0);
        // Fetch stalled 3 cycles; beq with both zero values.
        run_instr(RT, 1'b0, 3, 0);
        run_instr(BEQ, 1'b1, 0, 0);
        run_instr(BEQ, 1'b0, 0, 0);
        tie_ready = 0;

        // Illegal opcode halts; nothing leaves HALT but reset.
        run_instr(BAD, 1'b0, 0, 0);
        halt_cycles(4);
        do_reset();

        // MEMRD timeout on the 4th waiting cycle.
        step(PH_F, LW, 1'b0, 1'b1);
        step(PH_D, LW, 1'b0, 1'b0);
        step(PH_MA, LW, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(PH_MR, LW, 1'b0, 1'b0);
        sticky_berr = 1;
        halt_cycles(3);
        do_reset();
        // Ready arriving on the limit cycle is still a success.
        run_instr(LW, 1'b0, 0, 3);
        run_instr(SW, 1'b0, 3, 3);

        // FETCH timeout.
        for (int i = 0; i < 4; i++) step(PH_F, 6'($urandom), 1'b0, 1'b0);
        sticky_berr = 1;
        halt_cycles(2);
        do_reset();

        // Reset rising mid-cycle while a store is on the bus.
        step(PH_F, SW, 1'b0, 1'b1);
        step(PH_D, SW, 1'b0, 1'b1);
        step(PH_MA, SW, 1'b0, 1'b1);
        step(PH_MW, SW, 1'b0, 1'b0);
        do_reset();
        run_instr(LW, 1'b1, 0, 0);

        // Random legal traffic with random stalls below the limit.
        for (int n = 0; n < 60; n++)
            run_instr(legal[$urandom_range(0, 5)], 1'($urandom),
                      $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0,
                      $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);

        done = 1;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS datapath, which reuses one ALU and one unified memory across several cycles per instruction. It sequences fetch, decode, execute, memory and writeback, and emits every datapath select and enable per state. It waits on a memory-ready handshake and halts on illegal opcodes or memory timeouts. ALU function decode stays in the existing ALU control block, which is driven by alu_op.

Parameters:
WAIT_LIMIT, 255, maximum cycles one memory state may wait for mem_ready before a bus error.
WAIT_W, 8, width of the wait counter; WAIT_LIMIT must fit in WAIT_W bits.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
opcode  input  6  instruction register bits [31:26]; sampled in DECODE.
zero  input  1  ALU zero flag; used in BRANCH.
mem_ready  input  1  memory completes the current read/write this cycle.
pc_write  output  1  unconditional PC load.
pc_write_cond  output  1  PC load qualified by zero (beq).
iord  output  1  0 = memory address from PC, 1 = from ALUOut.
mem_read  output  1  memory read request.
mem_write  output  1  memory write request.
ir_write  output  1  instruction register load.
mem_to_reg  output  1  register write data: 0 = ALUOut, 1 = MDR.
reg_dst  output  1  destination register: 0 = rt, 1 = rd.
reg_write  output  1  register file write enable.
alu_src_a  output  1  ALU A input: 0 = PC, 1 = register A.
alu_src_b  output  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded.
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
halted  output  1  FSM is in HALT.
illegal_op  output  1  sticky: halt was caused by an unsupported opcode.
bus_error  output  1  sticky: halt was caused by a mem_ready timeout.

Behaviour:
- Reset: state = FETCH, wait counter = 0, sticky flags = 0. While reset is high every output is 0. This includes FETCH's own signals.
- Outputs are Moore decodes of the state. Exception: pc_write and ir_write in FETCH are additionally gated by mem_ready.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- FETCH:
  - Asserts mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - With mem_ready: also asserts ir_write and pc_write, then goes to DECODE.
  - Without mem_ready: stays in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - lw or sw -> MEMADR.
  - R-type -> EXECUTE.
  - beq -> BRANCH.
  - j -> JUMP.
  - addi -> ADDIEX.
  - anything else -> HALT, illegal_op set.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for lw, MEMWR for sw (opcode is held stable by the IR).
- MEMRD: mem_read=1, iord=1. Goes to MEMWB on mem_ready, otherwise waits.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEMWR: mem_write=1, iord=1. Goes to FETCH on mem_ready, otherwise waits.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- Wait counter (FETCH, MEMRD, MEMWR only):
  - Cleared on entry to each of these states and whenever mem_ready=1.
  - Increments each cycle the state waits with mem_ready=0.
  - If it reaches WAIT_LIMIT while mem_ready is still 0 -> HALT, bus_error set.
  - mem_ready=1 in the same cycle the counter hits the limit counts as success.
- HALT: all datapath enables are 0 and halted=1. Only reset leaves HALT.
- Cycles per instruction with zero-wait memory:
  - lw: 5.
  - sw, R-type, addi: 4.
  - beq, j: 3.
- Reset asserted mid-instruction: abandons the instruction immediately. No partial reg_write or mem_write is emitted after the reset edge.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB, HALT; 4-bit encoding);
  - the opcode constants;
  - the alu_op, alu_src_b and pc_source encodings.
- One sub-module, mc_wait_timer: clear/increment counter with a limit-reached output, parameterised by WAIT_LIMIT and WAIT_W.

Test Plan:
- mem_ready tied to 1; sequence lw, sw, add, addi, beq, j -> state traces of 5, 4, 4, 4, 3 and 3 cycles. Per-state control values exactly as listed above.
- FETCH with mem_ready low for 3 cycles -> ir_write and pc_write stay 0 for those 3 cycles, pulse for exactly 1 cycle when mem_ready rises, then DECODE.
- beq with zero=1 and zero=0 -> pc_write_cond=1 and pc_source=01 in BRANCH in both cases; next state FETCH.
- opcode 111111 in DECODE -> HALT next cycle; halted=1, illegal_op=1, bus_error=0. Further cycles show no enables; reset returns to FETCH with flags cleared.
- WAIT_LIMIT=4, MEMRD with mem_ready held 0 -> HALT after 4 waiting cycles, bus_error=1. A repeat run with mem_ready=1 on the 4th waiting cycle -> MEMWB, no error.
- reset asserted asynchronously during MEMWR (mem_write=1) -> all outputs 0 in the same cycle; after release, first state is FETCH with mem_read=1.
